// File: rtl/muldiv_pkg.sv
`default_nettype none
// muldiv_pkg: op codes, FSM states and iteration count shared by the
// multiply/divide unit.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam int ITER_COUNT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/muldiv_iter.sv
`default_nettype none
// muldiv_iter: one radix-2 step, shift-add multiply (mode_i=0) or
// restoring divide (mode_i=1, only with MULDIV_DIV_EN). Combinational.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  input  logic               mode_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic               q_o
);

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] mul_next;

  // Upper half accumulates the multiplicand; carry shifts in on the right-shift.
  always_comb begin
    sum      = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, (acc_i[0] ? opnd_i : {WIDTH{1'b0}})};
    mul_next = {sum, acc_i[WIDTH-1:1]};
  end

`ifdef MULDIV_DIV_EN
  logic [WIDTH:0]     diff;
  logic               q_bit;
  logic [2*WIDTH-1:0] div_next;

  // The shifted partial remainder needs one extra bit before the trial subtract.
  always_comb begin
    diff     = acc_i[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_i};
    q_bit    = ~diff[WIDTH];
    div_next = {(q_bit ? diff[WIDTH-1:0] : acc_i[2*WIDTH-2:WIDTH-1]),
                acc_i[WIDTH-2:0], 1'b0};
    acc_o    = mode_i ? div_next : mul_next;
    q_o      = mode_i & q_bit;
  end
`else
  logic unused_mode;
  assign unused_mode = mode_i;

  always_comb begin
    acc_o = mul_next;
    q_o   = 1'b0;
  end
`endif

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// muldiv_unit: iterative MIPS MULT/MULTU/DIV/DIVU with HI/LO and MTHI/MTLO.
// Define MULDIV_DIV_EN to build the divider; otherwise DIV/DIVU are reserved.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e             state_q;
  logic [4:0]         cnt_q;
  logic [2*WIDTH-1:0] acc_q, acc_d, iter_acc;
  logic               iter_q;
  logic [WIDTH-1:0]   opnd_q, hi_q, lo_q;
  logic               mode_q, neg_q, busy_q, done_q;
`ifdef MULDIV_DIV_EN
  logic               rneg_q, divz_q;
`endif

  logic               is_mul, is_div, is_sgn;
  logic [WIDTH-1:0]   a_mag, b_mag, fix_hi, fix_lo;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    is_mul = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MULDIV_DIV_EN
    is_div = (op == OP_DIV) || (op == OP_DIVU);
    is_sgn = (op == OP_MULT) || (op == OP_DIV);
`else
    is_div = 1'b0;
    is_sgn = (op == OP_MULT);
`endif
    a_mag = (is_sgn && a[WIDTH-1]) ? -a : a;
    b_mag = (is_sgn && b[WIDTH-1]) ? -b : b;
  end

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .mode_i (mode_q),
    .acc_o  (iter_acc),
    .q_o    (iter_q)
  );

  assign acc_d = {iter_acc[2*WIDTH-1:1], iter_acc[0] | iter_q};

  always_comb begin
    prod   = neg_q ? -acc_q : acc_q;
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
    // Divide by zero forces an all-ones quotient; the remainder already equals a.
    if (mode_q) begin
      fix_hi = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      fix_lo = divz_q ? {WIDTH{1'b1}} : (neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      mode_q  <= 1'b0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
      rneg_q  <= 1'b0;
      divz_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (is_mul || is_div) begin
              state_q <= RUN;
              busy_q  <= 1'b1;
              cnt_q   <= '0;
              acc_q   <= {{WIDTH{1'b0}}, a_mag};
              opnd_q  <= b_mag;
              mode_q  <= is_div;
              neg_q   <= is_sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef MULDIV_DIV_EN
              rneg_q  <= is_sgn & a[WIDTH-1];
              divz_q  <= (b == '0);
`endif
            end else if (op == OP_MTHI) begin
              hi_q   <= a;
              done_q <= 1'b1;
            end else if (op == OP_MTLO) begin
              lo_q   <= a;
              done_q <= 1'b1;
            end
          end
        end
        RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'(ITER_COUNT - 1)) state_q <= FIX;
        end
        FIX: begin
          hi_q    <= fix_hi;
          lo_q    <= fix_lo;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// tb_muldiv_unit: random + directed ops against a plain-arithmetic model,
// checked through a done-driven scoreboard.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] pred_hi = '0, pred_lo = '0;
  logic [31:0] cur_hi = '0, cur_lo = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: returns 1 when a done/HI-LO update is expected.
  function automatic bit model(input logic [2:0] o, input logic [31:0] av, bv,
                               input logic [31:0] ph, pl,
                               output logic [31:0] eh, el, output int lat, output bit it);
    longint p, sa, sb_, qv, rv;
    logic [63:0] up;
    eh = ph; el = pl; lat = 0; it = 1'b0;
    case (o)
      3'd0: begin
        sa = longint'($signed(av)); sb_ = longint'($signed(bv)); p = sa * sb_;
        up = 64'(p); eh = up[63:32]; el = up[31:0]; lat = 33; it = 1'b1; return 1'b1;
      end
      3'd1: begin
        up = 64'(av) * 64'(bv); eh = up[63:32]; el = up[31:0]; lat = 33; it = 1'b1; return 1'b1;
      end
`ifdef MULDIV_DIV_EN
      3'd2, 3'd3: begin
        lat = 33; it = 1'b1;
        if (bv == 0) begin
          el = 32'hFFFFFFFF; eh = av;
        end else begin
          if (o == 3'd2) begin sa = longint'($signed(av)); sb_ = longint'($signed(bv)); end
          else begin sa = longint'({32'b0, av}); sb_ = longint'({32'b0, bv}); end
          qv = sa / sb_; rv = sa % sb_;
          up = 64'(qv); el = up[31:0];
          up = 64'(rv); eh = up[31:0];
        end
        return 1'b1;
      end
`endif
      3'd4: begin eh = av; return 1'b1; end
      3'd5: begin el = av; return 1'b1; end
      default: return 1'b0;
    endcase
  endfunction

  // Monitor: pops on done, otherwise HI/LO must hold their last value.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      cur_hi = '0;
      cur_lo = '0;
    end else if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("hi", hi, e.hi);
        chk("lo", lo, e.lo);
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
        cur_hi = e.hi;
        cur_lo = e.lo;
      end
    end else begin
      chk("hi_hold", hi, cur_hi);
      chk("lo_hold", lo, cur_lo);
    end
  end

  // Called at a falling edge; returns at the falling edge where busy is low.
  task automatic issue(input logic [2:0] o, input logic [31:0] av, bv, input int inject);
    logic [31:0] eh, el;
    int lat, n;
    bit it, ex;
    exp_t e;
    ex = model(o, av, bv, pred_hi, pred_lo, eh, el, lat, it);
    start = 1'b1; op = o; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    if (ex) begin
      e.hi = eh; e.lo = el; e.cyc = cyc + lat;
      sb.push_back(e);
      pred_hi = eh; pred_lo = el;
    end
    chk("busy_after_accept", {31'b0, busy}, {31'b0, it});
    @(negedge clk);
    n = 0;
    while (busy && n < 40) begin
      if (n == inject) begin
        start = 1'b1; op = 3'd5; a = 32'hDEAD0000 | 32'(n);
      end
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      n++;
    end
    if (busy) chk("busy_timeout", {31'b0, busy}, 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h80000000;
      3: return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, -1);
    issue(3'd0, 32'hFFFFFFFD, 32'd7, -1);
    issue(3'd2, 32'hFFFFFFF9, 32'd2, -1);
    issue(3'd3, 32'd100, 32'd0, -1);
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF, -1);
    issue(3'd2, 32'hFFFFFFFB, 32'd0, -1);
    issue(3'd4, 32'h00001234, 32'd0, -1);
    issue(3'd0, 32'd3, 32'd4, 5);
    issue(3'd6, 32'h55555555, 32'd9, -1);
    issue(3'd5, 32'hCAFEF00D, 32'd0, -1);
    issue(3'd7, 32'h0BADBEEF, 32'd9, -1);

    for (int i = 0; i < 40; i++) begin
      issue(3'($urandom_range(0, 7)), pick(), pick(), (i % 4 == 0) ? int'($urandom_range(0, 30)) : -1);
    end

    // Abort a MULTU at T10: nothing may reach HI/LO and no done follows.
    issue(3'd1, 32'h89ABCDEF, 32'h12345678, -1);
    start = 1'b1; op = 3'd1; a = 32'd5; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    pred_hi = '0; pred_lo = '0;
    @(negedge clk); #2;
    reset = 1'b0;
    repeat (40) @(negedge clk);

    issue(3'd0, 32'h80000000, 32'h80000000, -1);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
